// File: rtl/reorder_buffer.sv
// reorder_buffer: 4-wide in-order-retire reorder buffer.
// Each row holds four micro-op entries. Dispatch writes one row per cycle at
// the tail. Execution and branch lanes clear busy and valid bits. The head row
// retires when none of its valid entries is still busy.
// Optional macro ROB_PC_STORE_EN: keep a PC per row and report it on commit;
// when undefined the PC input is ignored and o_com_pc is tied to zero.
module reorder_buffer #(
  parameter int WIDTH_REG  = 7,
  parameter int WIDTH_BRM  = 4,
  parameter int WIDTH_BANK = 3,
  localparam int W  = 2 + 7 + 32 + WIDTH_REG + WIDTH_BRM,
  localparam int TW = WIDTH_BANK + 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_dis_we,
  input  logic [31:0]            i_dis_pc,
  input  logic [4*W-1:0]         i_dis_data4x,
  input  logic [4*TW-1:0]        i_rst4x_busytg,
  input  logic [4*TW-1:0]        i_rst4x_valtg,
  output logic [WIDTH_BANK-1:0]  o_dis_tag,
  output logic                   o_full,
  output logic                   o_com_en,
  output logic [3:0]             o_com_val,
  output logic [4*WIDTH_REG-1:0] o_com_prd4x,
  output logic [31:0]            o_com_pc
);

  localparam int ROWS = 1 << WIDTH_BANK;

  logic [WIDTH_BANK-1:0] head;
  logic [WIDTH_BANK-1:0] tail;
  logic [WIDTH_BANK:0]   count;

  logic [3:0]           val_q  [ROWS];
  logic [3:0]           busy_q [ROWS];
  logic [WIDTH_REG-1:0] prd_q  [ROWS][4];

  logic com_en;
  logic dis_acc;

  // uop, imm and branch-mask fields are carried by dispatch but never read here
  logic unused_dis;
  assign unused_dis = ^i_dis_data4x;

  // The count MSB is set only when every row is occupied
  assign o_full    = count[WIDTH_BANK];
  assign o_dis_tag = tail;
  assign dis_acc   = i_dis_we && !count[WIDTH_BANK];

  // Head row retires when no entry is both valid and still busy
  always_comb begin
    com_en = (count != '0) && ((val_q[head] & busy_q[head]) == 4'b0000);
  end

  assign o_com_en = com_en;

  // Commit outputs come from registered state only; killed lanes read as zero
  always_comb begin
    o_com_val   = 4'b0000;
    o_com_prd4x = '0;
    if (com_en) begin
      o_com_val = val_q[head];
      for (int k = 0; k < 4; k++) begin
        if (val_q[head][k]) begin
          o_com_prd4x[k*WIDTH_REG +: WIDTH_REG] = prd_q[head][k];
        end
      end
    end
  end

  // Pointers, occupancy and status bits; later assignments override earlier ones,
  // so a dispatch write to an entry wins over a same-cycle clear of that entry
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int r = 0; r < ROWS; r++) begin
        val_q[r]  <= 4'b0000;
        busy_q[r] <= 4'b0000;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (i_rst4x_busytg[k*TW + TW - 1]) begin
          busy_q[i_rst4x_busytg[k*TW + 2 +: WIDTH_BANK]][i_rst4x_busytg[k*TW +: 2]] <= 1'b0;
        end
        if (i_rst4x_valtg[k*TW + TW - 1]) begin
          val_q[i_rst4x_valtg[k*TW + 2 +: WIDTH_BANK]][i_rst4x_valtg[k*TW +: 2]] <= 1'b0;
        end
      end
      if (com_en) begin
        val_q[head] <= 4'b0000;
        head        <= head + WIDTH_BANK'(1);
      end
      if (dis_acc) begin
        for (int k = 0; k < 4; k++) begin
          val_q[tail][k]  <= i_dis_data4x[k*W + W - 1];
          busy_q[tail][k] <= i_dis_data4x[k*W + W - 2];
        end
        tail <= tail + WIDTH_BANK'(1);
      end
      if (dis_acc && !com_en) begin
        count <= count + (WIDTH_BANK + 1)'(1);
      end else if (!dis_acc && com_en) begin
        count <= count - (WIDTH_BANK + 1)'(1);
      end
    end
  end

  // Destination register payload; only meaningful while the row's val bits are set
  always_ff @(posedge i_clk) begin
    if (dis_acc) begin
      for (int k = 0; k < 4; k++) begin
        prd_q[tail][k] <= i_dis_data4x[k*W + WIDTH_BRM +: WIDTH_REG];
      end
    end
  end

`ifdef ROB_PC_STORE_EN
  logic [31:0] pc_q [ROWS];

  // Per-row PC captured at dispatch
  always_ff @(posedge i_clk) begin
    if (dis_acc) begin
      pc_q[tail] <= i_dis_pc;
    end
  end

  assign o_com_pc = com_en ? pc_q[head] : 32'h0;
`else
  logic unused_pc;
  assign unused_pc = ^i_dis_pc;
  assign o_com_pc  = 32'h0;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed, table-driven checks for reorder_buffer.
module tb_reorder_buffer;

  localparam int W  = 52;
  localparam int TW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [31:0]   pc;
  logic [4*W-1:0]  data;
  logic [4*TW-1:0] btg;
  logic [4*TW-1:0] vtg;
  logic [2:0]    dis_tag;
  logic          full;
  logic          com_en;
  logic [3:0]    com_val;
  logic [27:0]   com_prd;
  logic [31:0]   com_pc;

  int checks = 0;
  int errors = 0;

  localparam logic [4*TW-1:0] NONE = '0;

  typedef struct {
    logic            rst;
    logic            we;
    logic [31:0]     pc;
    logic [4*W-1:0]  data;
    logic [4*TW-1:0] btg;
    logic [4*TW-1:0] vtg;
    logic            chk;
    logic [2:0]      tag;
    logic            full;
    logic            ce;
    logic [3:0]      cv;
    logic [27:0]     cp;
    logic [31:0]     cpc;
  } vec_t;

  vec_t vecs[$];

  reorder_buffer dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_dis_we       (we),
    .i_dis_pc       (pc),
    .i_dis_data4x   (data),
    .i_rst4x_busytg (btg),
    .i_rst4x_valtg  (vtg),
    .o_dis_tag      (dis_tag),
    .o_full         (full),
    .o_com_en       (com_en),
    .o_com_val      (com_val),
    .o_com_prd4x    (com_prd),
    .o_com_pc       (com_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mkEntry(logic v, logic b, logic [6:0] p);
    return {v, b, 7'h2a, 32'hcafe_0000, p, 4'h5};
  endfunction

  function automatic logic [4*W-1:0] mkRow(logic [3:0] v, logic [3:0] b,
                                          logic [6:0] p0, logic [6:0] p1,
                                          logic [6:0] p2, logic [6:0] p3);
    return {mkEntry(v[3], b[3], p3), mkEntry(v[2], b[2], p2),
            mkEntry(v[1], b[1], p1), mkEntry(v[0], b[0], p0)};
  endfunction

  function automatic logic [TW-1:0] mkLane(logic en, logic [2:0] row, logic [1:0] slot);
    return {en, row, slot};
  endfunction

  function automatic logic [27:0] prd4(logic [6:0] p3, logic [6:0] p2,
                                       logic [6:0] p1, logic [6:0] p0);
    return {p3, p2, p1, p0};
  endfunction

  function automatic vec_t mkVec(logic r, logic w, logic [31:0] p, logic [4*W-1:0] d,
                                 logic [4*TW-1:0] b, logic [4*TW-1:0] v, logic c,
                                 logic [2:0] tg, logic f, logic ce, logic [3:0] cv,
                                 logic [27:0] cp, logic [31:0] cpc);
    vec_t x;
    x.rst = r; x.we = w; x.pc = p; x.data = d; x.btg = b; x.vtg = v; x.chk = c;
    x.tag = tg; x.full = f; x.ce = ce; x.cv = cv; x.cp = cp; x.cpc = cpc;
    return x;
  endfunction

  // Drive one cycle of inputs just after the falling edge
  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] p,
                               input logic [4*W-1:0] d, input logic [4*TW-1:0] b,
                               input logic [4*TW-1:0] v);
    @(negedge clk);
    rst = r; we = w; pc = p; data = d; btg = b; vtg = v;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tagName, input logic [2:0] tg, input logic f,
                          input logic ce, input logic [3:0] cv, input logic [27:0] cp,
                          input logic [31:0] cpc);
    logic [31:0] expPc;
`ifdef ROB_PC_STORE_EN
    expPc = cpc;
`else
    expPc = 32'h0;
`endif
    checkOutput({tagName, ".dis_tag"}, {29'h0, dis_tag}, {29'h0, tg});
    checkOutput({tagName, ".full"},    {31'h0, full},    {31'h0, f});
    checkOutput({tagName, ".com_en"},  {31'h0, com_en},  {31'h0, ce});
    checkOutput({tagName, ".com_val"}, {28'h0, com_val}, {28'h0, cv});
    checkOutput({tagName, ".com_prd"}, {4'h0, com_prd},  {4'h0, cp});
    checkOutput({tagName, ".com_pc"},  com_pc,           expPc);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; pc = '0; data = '0; btg = '0; vtg = '0;

    vecs.push_back(mkVec(1, 0, 0, '0, NONE, NONE, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, '0, NONE, NONE, 1, 0, 0, 0, 0, 0, 0));
    for (int r = 0; r < 8; r++) begin
      vecs.push_back(mkVec(0, 1, 32'(r + 1),
                           mkRow(4'hf, 4'hf, 7'(4*r), 7'(4*r+1), 7'(4*r+2), 7'(4*r+3)),
                           NONE, NONE, 1, 3'(r), 0, 0, 0, 0, 0));
    end
    vecs.push_back(mkVec(0, 1, 32'h77, mkRow(4'hf, 4'hf, 7'h7f, 7'h7f, 7'h7f, 7'h7f),
                         NONE, NONE, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, '0,
                         {mkLane(1, 0, 3), mkLane(1, 0, 2), mkLane(1, 0, 1), mkLane(1, 0, 0)},
                         NONE, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 32'h99, mkRow(4'hf, 4'hf, 7'h55, 7'h55, 7'h55, 7'h55),
                         NONE, NONE, 1, 0, 1, 1, 4'hf, prd4(3, 2, 1, 0), 32'h1));
    vecs.push_back(mkVec(0, 1, 32'h99, mkRow(4'hf, 4'hf, 7'h55, 7'h55, 7'h55, 7'h55),
                         NONE, NONE, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, '0,
                         {mkLane(1, 1, 3), mkLane(1, 1, 1), mkLane(1, 1, 0), mkLane(0, 1, 2)},
                         NONE, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, '0,
                         {mkLane(1, 2, 3), mkLane(1, 2, 2), mkLane(1, 2, 1), mkLane(1, 2, 0)},
                         NONE, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, '0,
                         {mkLane(1, 1, 2), mkLane(1, 1, 2), 6'h0, 6'h0},
                         NONE, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, '0, NONE, NONE, 1, 1, 1, 1, 4'hf, prd4(7, 6, 5, 4), 32'h2));
    vecs.push_back(mkVec(0, 0, 0, '0, NONE, NONE, 1, 1, 0, 1, 4'hf, prd4(11, 10, 9, 8), 32'h3));
    vecs.push_back(mkVec(0, 0, 0, '0,
                         {mkLane(1, 3, 0), mkLane(1, 3, 2), mkLane(1, 3, 0), 6'h0},
                         {mkLane(1, 3, 1), mkLane(1, 3, 3), 6'h0, 6'h0},
                         1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, '0, NONE, NONE, 1, 1, 0, 1, 4'b0101, prd4(0, 14, 0, 12), 32'h4));
    vecs.push_back(mkVec(0, 0, 0, '0, NONE,
                         {mkLane(1, 4, 3), mkLane(1, 4, 2), mkLane(1, 4, 1), mkLane(1, 4, 0)},
                         1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, '0, NONE, NONE, 1, 1, 0, 1, 4'h0, 0, 32'h5));
    vecs.push_back(mkVec(1, 0, 0, '0, NONE, NONE, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 32'h100, mkRow(4'hf, 4'hf, 20, 21, 22, 23),
                         {mkLane(1, 0, 3), mkLane(1, 0, 2), mkLane(1, 0, 1), mkLane(1, 0, 0)},
                         NONE, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, '0, NONE, {18'h0, mkLane(1'bx, 0, 0)},
                         1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, '0,
                         {mkLane(1, 0, 3), mkLane(1, 0, 2), mkLane(1, 0, 1), mkLane(1, 0, 0)},
                         NONE, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 32'h200, mkRow(4'hf, 4'h0, 30, 31, 32, 33), NONE, NONE,
                         1, 1, 0, 1, 4'hf, prd4(23, 22, 21, 20), 32'h100));
    vecs.push_back(mkVec(0, 0, 0, '0, NONE, NONE, 1, 2, 0, 1, 4'hf, prd4(33, 32, 31, 30), 32'h200));
    vecs.push_back(mkVec(0, 0, 0, '0, NONE, NONE, 1, 2, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].we, vecs[i].pc, vecs[i].data, vecs[i].btg, vecs[i].vtg);
      if (vecs[i].chk) begin
        checkAll($sformatf("vec%0d", i), vecs[i].tag, vecs[i].full, vecs[i].ce,
                 vecs[i].cv, vecs[i].cp, vecs[i].cpc);
      end
    end

    // Back-to-back dispatch of ready rows: tag and head both wrap past row 7
    applyStimulus(1, 0, 0, '0, NONE, NONE);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 32'(i + 16),
                    mkRow(4'hf, 4'h0, 7'(4*i), 7'(4*i+1), 7'(4*i+2), 7'(4*i+3)),
                    NONE, NONE);
      if (i == 0) begin
        checkAll("wrap0", 3'd0, 0, 0, 0, 0, 0);
      end else begin
        checkAll($sformatf("wrap%0d", i), 3'(i), 0, 1, 4'hf,
                 prd4(7'(4*i-1), 7'(4*i-2), 7'(4*i-3), 7'(4*i-4)), 32'(i + 15));
      end
    end
    applyStimulus(0, 0, 0, '0, NONE, NONE);
    checkAll("wrapLast", 3'd2, 0, 1, 4'hf, prd4(39, 38, 37, 36), 32'd25);
    applyStimulus(0, 0, 0, '0, NONE, NONE);
    checkAll("wrapEmpty", 3'd2, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
